// File: rtl/ssd_mux.sv
// Multiplexed seven-segment driver: one digit lit per DIV cycles.
// Define SSD_MUX_HEX_EN to decode nibbles 10..15 as A..F.
module ssd_mux #(
  parameter int DIGITS       = 4,
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  blink_q, blink_d;
  logic [4*DIGITS-1:0]   val_q, val_d;
  logic [DIGITS-1:0]     dps_q, dps_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;

  logic                  cnt_wrap;
  logic                  idx_wrap;
  logic                  frame_wrap;
  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  lz_sel;
  logic                  bl_sel;
  logic                  hi_zero;
  logic [DIGITS-1:0]     lz_vec;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = ~7'h3F;
      4'h1: s = ~7'h06;
      4'h2: s = ~7'h5B;
      4'h3: s = ~7'h4F;
      4'h4: s = ~7'h66;
      4'h5: s = ~7'h6D;
      4'h6: s = ~7'h7D;
      4'h7: s = ~7'h07;
      4'h8: s = ~7'h7F;
      4'h9: s = ~7'h6F;
`ifdef SSD_MUX_HEX_EN
      4'hA: s = ~7'h77;
      4'hB: s = ~7'h7C;
      4'hC: s = ~7'h39;
      4'hD: s = ~7'h5E;
      4'hE: s = ~7'h79;
      4'hF: s = ~7'h71;
`else
      4'hA: s = ~7'h37;
`endif
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_wrap   = (cnt_q == CW'(DIV - 1));
    idx_wrap   = (idx_q == IW'(DIGITS - 1));
    frame_wrap = (frame_q == FW'(BLINK_FRAMES - 1));
    cnt_d   = cnt_wrap ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    frame_d = frame_q;
    blink_d = blink_q;
    if (cnt_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + IW'(1);
      if (idx_wrap) begin
        frame_d = frame_wrap ? '0 : frame_q + FW'(1);
        blink_d = blink_q ^ frame_wrap;
      end
    end
    val_d = load ? value : val_q;
    dps_d = load ? dp_in : dps_q;
  end

  // lz_vec[i]: digit i and every digit above it hold zero
  always_comb begin
    hi_zero = 1'b1;
    lz_vec  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero   = hi_zero & (val_q[i*4 +: 4] == 4'h0);
      lz_vec[i] = hi_zero & (i > 0);
    end
  end

  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    lz_sel = 1'b0;
    bl_sel = 1'b0;
    an_d   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib     = val_q[i*4 +: 4];
        dp_sel  = dps_q[i];
        lz_sel  = lz_vec[i];
        bl_sel  = blink_en[i];
        an_d[i] = 1'b0;
      end
    end
    seg_d = decode(nib);
    dp_d  = ~dp_sel;
    if (blank_lz && lz_sel) seg_d = 7'h7F;
    if (bl_sel && blink_q) begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      val_q   <= '0;
      dps_q   <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      val_q   <= val_d;
      dps_q   <= dps_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_ssd_mux.sv
// Directed self-checking bench for ssd_mux (DIGITS=4, DIV=4,
// BLINK_FRAMES=2).
module tb_ssd_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  blink_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ssd_mux #(
    .DIGITS(4),
    .DIV(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .value(value),
    .dp_in(dp_in),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .seg(seg),
    .dp(dp),
    .an(an)
  );

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] a;
    a = 4'hF;
    a[d] = 1'b0;
    return a;
  endfunction

  task automatic wait_an(input logic [3:0] pat, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (an === pat) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // lands on the first cycle of the digit-0 slot
  task automatic sync_frame(input string nm);
    bit ok1, ok2;
    wait_an(4'b0111, ok1);
    wait_an(4'b1110, ok2);
    n_cmp++;
    if (!(ok1 && ok2)) begin
      n_err++;
      $display("FAIL %s sync: an=%b never reached 1110", nm, an);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] ea;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1) begin
      n_err++;
      $display("FAIL reset: seg=%h an=%b dp=%b want 7f 1111 1",
               seg, an, dp);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (seg !== 7'h40 || an !== 4'b1110 || dp !== 1'b1) begin
      n_err++;
      $display("FAIL first: seg=%h an=%b dp=%b want 40 1110 1",
               seg, an, dp);
    end
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      ea = (k < 4) ? 4'b1110 : 4'b1101;
      n_cmp++;
      if (an !== ea) begin
        n_err++;
        $display("FAIL dwell c%0d: an=%b want %b", k, an, ea);
      end
    end
  endtask

  task automatic test_scan;
    logic [6:0] tbl [4];
    logic [3:0] ea;
    tbl[0] = 7'h19; tbl[1] = 7'h30;
    tbl[2] = 7'h24; tbl[3] = 7'h79;
    do_load(16'h1234, 4'h0);
    sync_frame("scan");
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      ea = an_of((k / 4) % 4);
      n_cmp++;
      if (an !== ea || seg !== tbl[(k/4)%4] || dp !== 1'b1) begin
        n_err++;
        $display("FAIL scan c%0d: an=%b seg=%h want %b %h",
                 k, an, seg, ea, tbl[(k/4)%4]);
      end
    end
  endtask

  task automatic test_lz;
    logic [6:0] t1 [4];
    logic [6:0] t2 [4];
    t1[0] = 7'h40; t1[1] = 7'h78; t1[2] = 7'h7F; t1[3] = 7'h7F;
    t2[0] = 7'h40; t2[1] = 7'h7F; t2[2] = 7'h7F; t2[3] = 7'h7F;
    blank_lz = 1'b1;
    do_load(16'h0070, 4'h0);
    sync_frame("lz70");
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (an !== an_of(k/4) || seg !== t1[k/4]) begin
        n_err++;
        $display("FAIL lz70 c%0d: an=%b seg=%h want %h",
                 k, an, seg, t1[k/4]);
      end
    end
    do_load(16'h0000, 4'h0);
    sync_frame("lz0");
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (an !== an_of(k/4) || seg !== t2[k/4]) begin
        n_err++;
        $display("FAIL lz0 c%0d: an=%b seg=%h want %h",
                 k, an, seg, t2[k/4]);
      end
    end
    blank_lz = 1'b0;
  endtask

  // restarts from reset so blink phase is known: cycle c shows
  // state c-1, phase 1 for states 32..63, 96..127
  task automatic test_blink;
    logic [6:0] es;
    logic       ed;
    int         d;
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    blink_en = 4'b0001;
    do_load(16'h0000, 4'b0001);
    for (int c = 2; c <= 130; c++) begin
      @(negedge clk);
      d  = ((c - 1) / 4) % 4;
      es = 7'h40;
      ed = (d == 0) ? 1'b0 : 1'b1;
      if (d == 0 && (((c - 1) / 32) % 2) == 1) begin
        es = 7'h7F;
        ed = 1'b1;
      end
      n_cmp++;
      if (an !== an_of(d) || seg !== es || dp !== ed) begin
        n_err++;
        $display("FAIL blink c%0d: an=%b seg=%h dp=%b want %b %h %b",
                 c, an, seg, dp, an_of(d), es, ed);
      end
    end
    blink_en = 4'b0000;
  endtask

  task automatic test_hex;
    logic [6:0] t [4];
    t[0] = 7'h40; t[1] = 7'h40;
`ifdef SSD_MUX_HEX_EN
    t[2] = 7'h08; t[3] = 7'h03;
`else
    t[2] = 7'h48; t[3] = 7'h7F;
`endif
    do_load(16'hBA00, 4'h0);
    sync_frame("hex");
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (an !== an_of(k/4) || seg !== t[k/4]) begin
        n_err++;
        $display("FAIL hex c%0d: an=%b seg=%h want %h",
                 k, an, seg, t[k/4]);
      end
    end
  endtask

  task automatic test_rst_mid;
    bit ok;
    do_load(16'h1234, 4'h0);
    wait_an(4'b1011, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL rstmid sync: an=%b want 1011", an);
    end
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'hFFFF;
    dp_in = 4'hF;
    @(negedge clk);
    load = 1'b0;
    n_cmp++;
    if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid: seg=%h an=%b dp=%b want 7f 1111 1",
               seg, an, dp);
    end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== an_of(k/4) || seg !== 7'h40 || dp !== 1'b1) begin
        n_err++;
        $display("FAIL rstmid c%0d: an=%b seg=%h dp=%b want %b 40 1",
                 k, an, seg, dp, an_of(k/4));
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    blank_lz = 1'b0;
    blink_en = '0;
    test_reset;
    test_scan;
    test_lz;
    test_blink;
    test_hex;
    test_rst_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
